// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared types and defaults for the FIFO stream reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 16;
    localparam int CNT_WIDTH_DEFAULT  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // An unknown encoding reports full so that it can never trigger extra reads.
    function automatic logic [1:0] occ_count(input occ_state_t s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_skid_buf
//  Description : Two-entry in-order output buffer with occupancy state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output occ_state_t       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= EMPTY;
            head   <= '0;
            r_tail <= '0;
        end else begin
            case (occ)
                EMPTY: begin
                    if (wr) begin
                        head <= wdata;
                        occ  <= ONE;
                    end
                end
                ONE: begin
                    if (wr && pop) begin
                        head <= wdata;
                    end else if (wr) begin
                        r_tail <= wdata;
                        occ    <= TWO;
                    end else if (pop) begin
                        occ <= EMPTY;
                    end
                end
                TWO: begin
                    // Upstream gating keeps wr low here; the wr path only preserves order if that ever breaks.
                    if (pop) begin
                        head <= r_tail;
                        if (wr) begin
                            r_tail <= wdata;
                        end else begin
                            occ <= ONE;
                        end
                    end
                end
                default: occ <= EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Drains a 1-cycle-latency FIFO into a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_INC = 1;

    occ_state_t w_occ;
    logic       r_inflight;
    logic       w_pop;
    logic       w_capture;
    logic [2:0] w_level;

    assign m_valid   = (w_occ != EMPTY);
    assign w_pop     = m_valid & m_ready;
    assign w_capture = r_inflight & ~fifo_underflow;

    // Occupancy after the coming edge if no new read were issued; a read is allowed only when it fits.
    assign w_level    = {1'b0, occ_count(w_occ)} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en = ~rst & en & ~fifo_empty & (w_level < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            err_underflow <= 1'b0;
            words_out     <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight && fifo_underflow) begin
                err_underflow <= 1'b1;
            end
            if (w_pop) begin
                words_out <= words_out + C_CNT_INC;
            end
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .wr    (w_capture),
        .wdata (fifo_data_out),
        .pop   (w_pop),
        .occ   (w_occ),
        .head  (m_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed self-checking bench with a behavioural FIFO and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          err_underflow;
    logic [CW-1:0] words_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .err_underflow  (err_underflow),
        .words_out      (words_out)
    );

    // Behavioural FIFO: 1-cycle registered read data.
    logic [W-1:0] fmem [0:2047];
    int fwr = 0;
    int frd = 0;
    assign fifo_empty = (fwr == frd);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= fmem[frd[10:0]];
            frd <= frd + 1;
        end
    end

    logic [W-1:0] exp_q [$];

    // Event counters since the last reset.
    int   reads = 0;
    int   pops = 0;
    int   drops = 0;
    int   max_out = 0;
    int   viol_empty = 0;
    int   viol_rst = 0;
    logic tb_inflight = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            reads = 0;
            pops  = 0;
            drops = 0;
        end else begin
            if (fifo_rd_en) reads++;
            if (m_valid && m_ready) pops++;
            if (tb_inflight && fifo_underflow) drops++;
        end
        tb_inflight <= fifo_rd_en;
    end

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (fifo_rd_en && fifo_empty) viol_empty++;
        if (rst && fifo_rd_en) viol_rst++;
        if (reads - pops - drops > max_out) max_out = reads - pops - drops;
        if (!rst && prev_stall) begin
            checks++;
            assert (m_valid === 1'b1 && m_data === prev_data) else begin
                errors++;
                $error("FAIL hold observed=%b/%h expected=1/%h", m_valid, m_data, prev_data);
            end
        end
        prev_stall = !rst && m_valid && !m_ready;
        prev_data  = m_data;
        if (!rst && m_valid && m_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL order observed=%h expected=<no word>", m_data);
            end
            if (exp_q.size() > 0) begin
                assert (m_data === exp_q[0]) else begin
                    errors++;
                    $error("FAIL order observed=%h expected=%h", m_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input bit expect_out);
        fmem[fwr[10:0]] = d;
        fwr++;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(exp_q.size() == 0 && !m_valid), 1);
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k;
        k = 0;
        while (!m_valid && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(m_valid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int p0;
        int k;

        rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
        cyc(2);

        // Reset while traffic is flowing.
        rst = 1'b0; en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(16'(16'h0100 + i), 1'b1);
        cyc(4);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        cyc(2);
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_err", 32'(err_underflow), 0);
        chk("rst_words", 32'(words_out), 0);
        chk("rst_rd_en2", 32'(fifo_rd_en), 0);
        cyc(1);
        en = 1'b0;
        fwr = frd;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(m_valid), 0);

        // Eight words back to back.
        cyc(1);
        for (int i = 1; i <= 8; i++) push(16'(i), 1'b1);
        en = 1'b1; m_ready = 1'b1;
        wait_valid("t2_first", 10);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_valid", 32'(m_valid), 1);
            chk("t2_data", 32'(m_data), 32'(i));
            @(negedge clk);
        end
        chk("t2_words", 32'(words_out), 8);
        chk("t2_idle", 32'(m_valid), 0);
        chk("t2_rd_empty", 32'(viol_empty), 0);

        // Backpressure: two reads fill the buffer, then reads stop.
        cyc(1);
        m_ready = 1'b0;
        r0 = reads;
        for (int i = 1; i <= 5; i++) push(16'(16'h0300 + i), 1'b1);
        cyc(8);
        @(negedge clk);
        chk("t3_reads", 32'(reads - r0), 2);
        chk("t3_rd_en", 32'(fifo_rd_en), 0);
        chk("t3_valid", 32'(m_valid), 1);
        chk("t3_data", 32'(m_data), 32'h0301);
        cyc(1);
        m_ready = 1'b1;
        p0 = pops;
        drain("t3_drain", 20);
        chk("t3_pops", 32'(pops - p0), 5);
        chk("t3_words", 32'(words_out), 13);

        // Random backpressure and enable over 1000 words.
        cyc(1);
        for (int i = 0; i < 1000; i++) push(16'($urandom), 1'b1);
        k = 0;
        while (exp_q.size() > 0 && k < 5000) begin
            m_ready = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 3) != 0);
            cyc(1);
            k++;
        end
        en = 1'b1; m_ready = 1'b1;
        drain("t4_drain", 20);
        chk("t4_max_occ", 32'(max_out <= 2), 1);
        chk("t4_words", 32'(words_out), 1013);

        // Underflow-flagged return is dropped and latched.
        cyc(1);
        fifo_underflow = 1'b1;
        push(16'hDEAD, 1'b0);
        cyc(4);
        @(negedge clk);
        chk("t5_err", 32'(err_underflow), 1);
        chk("t5_valid", 32'(m_valid), 0);
        chk("t5_words", 32'(words_out), 1013);
        chk("t5_drops", 32'(drops), 1);
        cyc(1);
        fifo_underflow = 1'b0;
        push(16'h0505, 1'b1);
        drain("t5_next", 20);
        chk("t5_err_sticky", 32'(err_underflow), 1);
        chk("t5_words2", 32'(words_out), 1014);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("t5_err_clr", 32'(err_underflow), 0);
        chk("t5_words_clr", 32'(words_out), 0);

        // Bring the counter to 0xFFFE, then en falls with a read in flight.
        cyc(1);
        rst = 1'b0; en = 1'b1; m_ready = 1'b1;
        for (int n = 0; n < 65534; n++) begin
            push(16'(n * 3 + 1), 1'b1);
            cyc(1);
        end
        drain("t6_bulk", 20);
        chk("t6_words_fffe", 32'(words_out), 32'hFFFE);
        cyc(1);
        m_ready = 1'b0;
        r0 = reads;
        push(16'hA0A0, 1'b1);
        push(16'hB0B0, 1'b1);
        cyc(1);
        en = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("t6_valid", 32'(m_valid), 1);
        chk("t6_data", 32'(m_data), 32'hA0A0);
        chk("t6_reads", 32'(reads - r0), 1);
        cyc(3);
        @(negedge clk);
        chk("t6_no_reads", 32'(reads - r0), 1);
        chk("t6_rd_en", 32'(fifo_rd_en), 0);
        cyc(1);
        m_ready = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("t6_words_ffff", 32'(words_out), 32'hFFFF);
        chk("t6_idle", 32'(m_valid), 0);
        cyc(1);
        en = 1'b1;
        drain("t6_tail", 10);
        chk("t6_words_wrap", 32'(words_out), 0);

        chk("rd_while_empty", 32'(viol_empty), 0);
        chk("rd_while_rst", 32'(viol_rst), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
